// File: rtl/sd_adc_pkg.sv
// Shared audio-path definitions for the delta-sigma ADC front end.
// Holds the sample width, the excess-128 mid-scale code, the default decimation
// window and the sample type that the capture and playback sides agree on.
package sd_adc_pkg;

  // MSB index of an audio sample; the audio path is fixed at 8 bits.
  localparam int unsigned MSBI = 7;

  // Excess-128 zero: the code for 50% ones density.
  localparam logic [MSBI:0] MIDSCALE = 8'h80;

  // Default window length is 2**DECIM_LOG2_DEF modulator clocks.
  localparam int unsigned DECIM_LOG2_DEF = 10;

  // Legal window exponents.
  localparam int unsigned DECIM_LOG2_MIN = 8;
  localparam int unsigned DECIM_LOG2_MAX = 16;

  typedef logic [MSBI:0] sample_t;

endpackage

// File: rtl/sd_adc_if.sv
// Sample handshake between the delta-sigma ADC and the audio path.
//   sample_o  : decimated sample, excess-128 (producer -> consumer)
//   valid_o   : sample_o holds an unconsumed sample (producer -> consumer)
//   ready_i   : consumer takes the sample when valid_o && ready_i
//   overrun_o : sticky flag, an unconsumed sample was overwritten
//   clr_ovr_i : consumer request to clear overrun_o
// Signal names keep the producer's point of view so they read the same on both
// sides of the link.
interface sd_adc_if;
  import sd_adc_pkg::*;

  sample_t sample_o;
  logic    valid_o;
  logic    ready_i;
  logic    overrun_o;
  logic    clr_ovr_i;

  // ADC side.
  modport master (
    output sample_o,
    output valid_o,
    output overrun_o,
    input  ready_i,
    input  clr_ovr_i
  );

  // Audio-path side.
  modport slave (
    input  sample_o,
    input  valid_o,
    input  overrun_o,
    output ready_i,
    output clr_ovr_i
  );

endinterface

// File: rtl/sd_adc_decim.sv
// Boxcar decimator for the delta-sigma ADC.
// Counts ones of the resynchronised modulator bit over 2**DECIM_LOG2 cycles,
// saturates the count so a full window of ones maps to all-ones, and keeps the
// top MSBI+1 bits as the sample. The first window after reset is discarded
// while the analogue loop settles.
// Ports:
//   clk_i      : modulator / system clock
//   rst_i      : synchronous active-high reset
//   bit_i      : modulator bit (the feedback bit) for the current cycle
//   win_done_o : one-cycle strobe, sample_o holds a fresh window result
//   sample_o   : last window result (excess 2**MSBI)
module sd_adc_decim
  import sd_adc_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    bit_i,
  output logic    win_done_o,
  output sample_t sample_o
);

  logic [DECIM_LOG2-1:0] wc_q, wc_d;
  // One extra bit so a full window of ones (2**DECIM_LOG2) is representable.
  logic [DECIM_LOG2:0]   acc_q, acc_d;
  logic                  warm_q, warm_d;
  logic                  done_q, done_d;
  sample_t               res_q, res_d;

  logic [DECIM_LOG2:0]   cnt;
  logic [DECIM_LOG2-1:0] sat;
  logic                  eow;

  always_comb begin
    // Final count includes this cycle's bit so the window sees exactly
    // 2**DECIM_LOG2 bits and the restart at zero loses nothing.
    cnt    = acc_q + {{DECIM_LOG2{1'b0}}, bit_i};
    eow    = &wc_q;
    sat    = cnt[DECIM_LOG2] ? '1 : cnt[DECIM_LOG2-1:0];

    wc_d   = wc_q + DECIM_LOG2'(1);
    acc_d  = eow ? '0 : cnt;
    warm_d = eow ? 1'b0 : warm_q;
    done_d = eow & ~warm_q;
    res_d  = (eow & ~warm_q) ? sat[DECIM_LOG2-1 -: MSBI+1] : res_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wc_q   <= '0;
      acc_q  <= '0;
      warm_q <= 1'b1;
      done_q <= 1'b0;
      res_q  <= MIDSCALE;
    end else begin
      wc_q   <= wc_d;
      acc_q  <= acc_d;
      warm_q <= warm_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign win_done_o = done_q;
  assign sample_o   = res_q;

endmodule

// File: rtl/sd_adc.sv
// First-order delta-sigma ADC front end.
// An external comparator (input vs RC-integrated feedback) drives cmp_i. The
// bit is resynchronised through two flops; the second flop is the feedback bit
// returned on fb_o and also the modulator bit fed to the decimator. Decimated
// samples are offered to the audio path over a valid/ready handshake with a
// sticky overrun flag.
// Ports:
//   clk_i : system and modulator clock
//   rst_i : synchronous active-high reset
//   cmp_i : asynchronous comparator output, 1 = input above feedback
//   fb_o  : registered feedback bit to the RC integrator
//   aud   : sample handshake (sample_o, valid_o, ready_i, overrun_o, clr_ovr_i)
module sd_adc
  import sd_adc_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = DECIM_LOG2_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     cmp_i,
  output logic     fb_o,
  sd_adc_if.master aud
);

  if (DECIM_LOG2 < DECIM_LOG2_MIN || DECIM_LOG2 > DECIM_LOG2_MAX) begin : g_bad_decim
    $error("sd_adc: DECIM_LOG2 must be in 8..16");
  end

  logic    s1_q, s1_d;
  logic    s2_q, s2_d;
  sample_t sample_q, sample_d;
  logic    valid_q, valid_d;
  logic    ovr_q, ovr_d;

  logic    win_done;
  sample_t win_sample;
  logic    ovr_set;

  sd_adc_decim #(
    .DECIM_LOG2 (DECIM_LOG2)
  ) u_decim (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bit_i      (s2_q),
    .win_done_o (win_done),
    .sample_o   (win_sample)
  );

  always_comb begin
    s1_d     = cmp_i;
    s2_d     = s1_q;

    sample_d = win_done ? win_sample : sample_q;

    // A publish keeps valid high whether or not the old sample is taken this
    // cycle; otherwise a consume drops it.
    valid_d  = win_done | (valid_q & ~aud.ready_i);

    // Overrun only when the old sample is still unconsumed as the new one lands.
    ovr_set  = win_done & valid_q & ~aud.ready_i;
    ovr_d    = ovr_set | (ovr_q & ~aud.clr_ovr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign fb_o          = s2_q;
  assign aud.sample_o  = sample_q;
  assign aud.valid_o   = valid_q;
  assign aud.overrun_o = ovr_q;

endmodule

// File: tb/tb_sd_adc.sv
// Self-checking bench for sd_adc with a 256-cycle window.
// A reference model samples the driven inputs on every rising edge, counts the
// ones density of each window from the comparator history (delayed two cycles),
// and schedules the expected samples; a monitor on the falling edge pops and
// compares them and also checks the handshake flags every cycle.
module tb_sd_adc;
  import sd_adc_pkg::*;

  localparam int D = 8;
  localparam int N = 1 << D;

  logic clk = 1'b0;
  logic rst;
  logic cmp;
  logic fb;

  sd_adc_if aud ();

  sd_adc #(
    .DECIM_LOG2 (D)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cmp_i (cmp),
    .fb_o  (fb),
    .aud   (aud)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend_q[$];
  int   hist[$];
  int   cyc_m = 0;
  int   wcnt = 0;
  logic ev = 1'b0;
  logic eo = 1'b0;
  logic [7:0] es = 8'h80;
  bit   armed = 1'b0;

  bit   first_chk = 1'b0;
  bit   rc_on = 1'b0;
  bit   rnd_hs = 1'b0;
  int   rc_n = 0;
  int   rc_k = 0;
  int   rc_sum = 0;
  int   pcnt = 0;
  real  vrc = 0.75;
  real  vin = 0.75;
  real  alpha = 1.0 / 1024.0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc_m);
    end
  endtask

  // Reference model: cycle c is the interval after the c-th non-reset edge
  // following reset; the modulator bit in cycle c is cmp from cycle c-2.
  initial forever begin : model
    int   s2;
    int   v;
    bit   pub;
    exp_t e;
    @(posedge clk);
    if (rst) begin
      cyc_m = 0;
      hist.delete();
      wcnt = 0;
      pend_q.delete();
      exp_q.delete();
      ev = 1'b0;
      eo = 1'b0;
      es = 8'h80;
      armed = 1'b1;
    end else begin
      s2 = (cyc_m >= 2) ? hist[cyc_m-2] : 0;
      hist.push_back(int'(cmp));
      wcnt += s2;
      pub = (pend_q.size() > 0) && (pend_q[0].cyc == cyc_m + 1);
      if (pub) begin
        if (ev && !aud.ready_i) eo = 1'b1;
        else if (aud.clr_ovr_i) eo = 1'b0;
        ev = 1'b1;
        es = 8'(pend_q[0].val);
        void'(pend_q.pop_front());
      end else begin
        if (ev && aud.ready_i) ev = 1'b0;
        if (aud.clr_ovr_i) eo = 1'b0;
      end
      if ((cyc_m + 1) % N == 0) begin
        // Window just ended; the first one after reset is discarded.
        if ((cyc_m + 1) / N >= 2) begin
          v = (wcnt > N - 1) ? N - 1 : wcnt;
          v = v >> (D - 8);
          e.cyc = cyc_m + 2;
          e.val = v;
          pend_q.push_back(e);
          exp_q.push_back(e);
        end
        wcnt = 0;
      end
      cyc_m++;
    end
  end

  // Monitor / scoreboard.
  initial forever begin : monitor
    exp_t e;
    int   s;
    @(negedge clk);
    if (armed) begin
      chk("valid", 32'(aud.valid_o), 32'(ev));
      chk("overrun", 32'(aud.overrun_o), 32'(eo));
      chk("sample", 32'(aud.sample_o), 32'(es));
      if (cyc_m >= 2) chk("fb", 32'(fb), 32'(hist[cyc_m-2]));
      else chk("fb_reset", 32'(fb), 32'd0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc_m) begin
        e = exp_q.pop_front();
        chk("pub_valid", 32'(aud.valid_o), 32'd1);
        chk("pub_sample", 32'(aud.sample_o), 32'(e.val));
        if (rc_on) begin
          rc_n++;
          if (rc_n > 2) begin
            s = int'(aud.sample_o);
            tests++;
            if (s < 188 || s > 196) begin
              fails++;
              $display("FAIL rc_range: got %0h, expected c0 within 4", s);
            end
            rc_sum += s;
            rc_k++;
          end
        end
      end
      if (first_chk && cyc_m == 2 * N) chk("first_valid_early", 32'(aud.valid_o), 32'd0);
      if (first_chk && cyc_m == 2 * N + 1) begin
        chk("first_valid", 32'(aud.valid_o), 32'd1);
        chk("first_sample", 32'(aud.sample_o), 32'hFF);
      end
    end
  end

  task automatic run(input int ncyc, input int mode);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      case (mode)
        0: cmp = 1'b0;
        1: cmp = 1'b1;
        2: cmp = (pcnt % 2 == 0);
        3: cmp = (pcnt % 4 == 0);
        4: cmp = 1'($urandom_range(0, 1));
        default: begin
          vrc = vrc + alpha * ((fb ? 1.0 : 0.0) - vrc);
          cmp = (vin > vrc);
        end
      endcase
      pcnt++;
      if (rnd_hs) begin
        aud.ready_i   = ($urandom_range(0, 3) != 0);
        aud.clr_ovr_i = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  // Stop at the negedge of the cycle whose closing edge publishes.
  task automatic wait_pub();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (pend_q.size() > 0 && pend_q[0].cyc == cyc_m + 1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_pub: got no publish, expected one within %0d cycles", 3 * N);
    end
  endtask

  task automatic reset_checks();
    chk("rst_valid", 32'(aud.valid_o), 32'd0);
    chk("rst_sample", 32'(aud.sample_o), 32'h80);
    chk("rst_overrun", 32'(aud.overrun_o), 32'd0);
    chk("rst_fb", 32'(fb), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cmp = 1'b0;
    aud.ready_i = 1'b0;
    aud.clr_ovr_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1'b0;
    aud.ready_i = 1'b1;
    cmp = 1'b1;
    first_chk = 1'b1;
    run(3 * N, 1);
    first_chk = 1'b0;

    run(4 * N, 2);
    run(4 * N, 3);
    run(4 * N, 0);

    // Two publishes with no consumer.
    aud.ready_i = 1'b0;
    run(2 * N + 8, 2);
    chk("ovr_set", 32'(aud.overrun_o), 32'd1);
    chk("ovr_valid", 32'(aud.valid_o), 32'd1);

    wait_pub();
    @(negedge clk);
    @(negedge clk);
    aud.clr_ovr_i = 1'b1;
    @(negedge clk);
    aud.clr_ovr_i = 1'b0;
    chk("ovr_clr", 32'(aud.overrun_o), 32'd0);

    wait_pub();
    aud.clr_ovr_i = 1'b1;
    @(negedge clk);
    aud.clr_ovr_i = 1'b0;
    chk("ovr_set_wins", 32'(aud.overrun_o), 32'd1);
    aud.clr_ovr_i = 1'b1;
    @(negedge clk);
    aud.clr_ovr_i = 1'b0;

    // Consume on the publish cycle only.
    wait_pub();
    aud.ready_i = 1'b1;
    @(negedge clk);
    aud.ready_i = 1'b0;
    chk("same_cycle_valid", 32'(aud.valid_o), 32'd1);
    chk("same_cycle_ovr", 32'(aud.overrun_o), 32'd0);

    rnd_hs = 1'b1;
    run(6 * N, 4);
    rnd_hs = 1'b0;
    aud.ready_i = 1'b1;
    aud.clr_ovr_i = 1'b0;

    // One-cycle reset at window position 100.
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (cyc_m % N == 100) break;
    end
    rst = 1'b1;
    @(negedge clk);
    reset_checks();
    rst = 1'b0;
    cmp = 1'b1;
    first_chk = 1'b1;
    run(2 * N + 4, 1);
    first_chk = 1'b0;

    // Closed loop against a behavioural RC integrator at 0.75 Vref.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vrc = 0.75;
    cmp = 1'b0;
    rc_on = 1'b1;
    run(12 * N, 5);
    rc_on = 1'b0;
    tests++;
    if (rc_k == 0 || rc_sum > 193 * rc_k || rc_sum < 191 * rc_k) begin
      fails++;
      $display("FAIL rc_avg: got sum %0d over %0d samples, expected mean c0 within 1",
               rc_sum, rc_k);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
